// File: rtl/pulse_transmitter_v2.sv
// pulse_transmitter_v2: register-programmed two-bit symbol pulse generator with loops, optional carrier (PULSE_TX_V2_CARRIER_EN)
module pulse_transmitter_v2 #(
  parameter int DATA_WORDS = 8,
  parameter int DUR_W      = 8,
  parameter int PRESC_W    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);
  localparam int IW = $clog2(DATA_WORDS * 16);
  localparam int WW = $clog2(DATA_WORDS);
  localparam int CW = DUR_W + (1 << PRESC_W) - 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

  state_t             r_state, w_state_nxt;
  logic [31:0]        r_ctrl;
  logic [PRESC_W-1:0] r_presc;
  logic [DUR_W-1:0]   r_dur [4];
  logic [31:0]        r_data [DATA_WORDS];
  logic               r_end_p, r_loop_p, r_start_d;
  logic [IW-1:0]      r_pc;
  logic [7:0]         r_loops;
  logic [CW-1:0]      r_cnt;
  logic [1:0]         r_sym;

  logic          w_wr32, w_clr, w_last, w_at_end, w_loop_ev, w_end_ev, w_valid, w_busy;
  logic          w_car, w_gate, w_pin, w_unused;
  logic [15:0]   w_half;
  logic [IW-1:0] w_end_idx, w_lb_idx, w_fetch_pc;
  logic [1:0]    w_fetch_sym;
  logic [CW:0]   w_len;
  logic [31:0]   w_status;

  assign w_wr32      = data_write_n == 2'b10;
  assign w_clr       = data_write_n != 2'b11 && address == 6'h18;
  assign w_end_idx   = r_ctrl[24 +: IW];
  assign w_lb_idx    = r_ctrl[16 +: IW];
  assign w_last      = r_state == S_RUN && r_cnt == '0;
  assign w_at_end    = r_pc == w_end_idx;
  assign w_loop_ev   = w_last && w_at_end && r_loops != 8'd0 && r_ctrl[0];
  assign w_end_ev    = w_last && w_at_end && r_loops == 8'd0 && r_ctrl[0];
  assign w_fetch_pc  = r_state == S_LOAD ? '0 : (w_at_end ? w_lb_idx : r_pc + IW'(1));
  assign w_fetch_sym = r_data[w_fetch_pc[IW-1:4]][{w_fetch_pc[3:0], 1'b0} +: 2];
  assign w_len       = ({{(CW + 1 - DUR_W){1'b0}}, r_dur[w_fetch_sym]} + (CW + 1)'(1)) << r_presc;
  assign w_valid     = r_state == S_RUN;
  assign w_busy      = r_state != S_IDLE;
  assign w_pin       = (w_valid ? (r_sym[1] & w_gate) : r_ctrl[1]) ^ r_ctrl[2];
  assign w_status    = {8'd0, r_loops, 8'(r_pc), 5'd0, r_loop_p, r_end_p, w_busy};
  assign uo_out      = {4'd0, w_valid, w_pin, w_car, 1'b0};
  assign data_ready  = 1'b1;
  assign user_interrupt = (r_end_p & r_ctrl[4]) | (r_loop_p & r_ctrl[5]);
  assign w_unused    = ^{ui_in, data_read_n, address[1:0], r_ctrl};

`ifdef PULSE_TX_V2_CARRIER_EN
  logic [15:0] r_half, r_car_cnt;
  logic        r_car;
  assign w_half = r_half;
  assign w_car  = r_car;
  assign w_gate = r_ctrl[3] ? r_car : 1'b1;
  // carrier half-period register and free-running toggle while busy
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_half    <= '0;
      r_car_cnt <= '0;
      r_car     <= 1'b0;
    end else begin
      if (w_wr32 && address == 6'h04) r_half <= data_in[15:0];
      if (!w_busy) begin
        r_car_cnt <= '0;
        r_car     <= 1'b0;
      end else if (r_car_cnt == r_half) begin
        r_car_cnt <= '0;
        r_car     <= ~r_car;
      end else r_car_cnt <= r_car_cnt + 16'd1;
    end
`else
  assign w_half = '0;
  assign w_car  = 1'b0;
  assign w_gate = 1'b1;
`endif

  // symbol sequencer next state: start edge, abort on start low, finish on final symbol
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == S_IDLE) w_state_nxt = (r_ctrl[0] && !r_start_d) ? S_LOAD : S_IDLE;
    else if (!r_ctrl[0] || w_end_ev) w_state_nxt = S_IDLE;
    else if (r_state == S_LOAD) w_state_nxt = S_RUN;
  end

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_state_nxt;

  // program counter, loop counter and symbol timer; next symbol is fetched on the completing cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_start_d <= 1'b0;
      r_pc      <= '0;
      r_loops   <= '0;
      r_cnt     <= '0;
      r_sym     <= '0;
    end else begin
      r_start_d <= r_ctrl[0];
      if (w_state_nxt == S_IDLE) begin
        r_pc    <= '0;
        r_loops <= '0;
        r_cnt   <= '0;
        r_sym   <= '0;
      end else if (r_state == S_LOAD || w_last) begin
        r_pc  <= w_fetch_pc;
        r_sym <= w_fetch_sym;
        r_cnt <= CW'(w_len - (CW + 1)'(1));
        if (r_state == S_LOAD) r_loops <= r_ctrl[15:8];
        else if (w_loop_ev) r_loops <= r_loops - 8'd1;
      end else if (r_state == S_RUN) r_cnt <= r_cnt - CW'(1);
    end

  // configuration registers and sticky pending flags (a set beats a same-cycle clear)
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_ctrl   <= '0;
      r_presc  <= '0;
      r_dur    <= '{default: '0};
      r_end_p  <= 1'b0;
      r_loop_p <= 1'b0;
    end else begin
      if (w_wr32 && address == 6'h00) r_ctrl <= data_in;
      if (w_wr32 && address == 6'h04) r_presc <= data_in[16 +: PRESC_W];
      if (w_wr32 && !address[5] && address[4:2] >= 3'd2 && address[4:2] <= 3'd5)
        r_dur[2'(address[4:2] - 3'd2)] <= data_in[DUR_W-1:0];
      r_end_p  <= w_end_ev | (r_end_p & ~(w_clr & data_in[1]));
      r_loop_p <= w_loop_ev | (r_loop_p & ~(w_clr & data_in[2]));
    end

  // symbol memory keeps its contents across reset
  always_ff @(posedge clk)
    if (w_wr32 && address[5]) r_data[address[2 +: WW]] <= data_in;

  // register read-back
  always_comb begin
    data_out = '0;
    if (address[5]) data_out = r_data[address[2 +: WW]];
    else
      case (address[4:2])
        3'd0:                   data_out = r_ctrl;
        3'd1:                   data_out = {12'd0, 4'(r_presc), w_half};
        3'd2, 3'd3, 3'd4, 3'd5: data_out = 32'(r_dur[2'(address[4:2] - 3'd2)]);
        3'd6:                   data_out = w_status;
        default:                data_out = '0;
      endcase
  end
endmodule
